playseq_leitor_jogada: RTL and testbench



---
 rtl/playseq_leitor_jogada_pkg.sv | 20 ++
 rtl/playseq_sincronizador.sv | 35 +++
 rtl/playseq_leitor_jogada.sv | 114 +++++++++++
 tb/tb_playseq_leitor_jogada.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/playseq_leitor_jogada_pkg.sv
`default_nettype none
// ===========================================================================
// playseq_defs : shared state encodings and default sizes for the PlaySeq
//                player-input front end.                         rev 1.0
// ===========================================================================
package playseq_defs;

   localparam int N_BOTOES_PADRAO        = 4;
   localparam int DEBOUNCE_CICLOS_PADRAO = 50000;

   typedef enum logic [2:0] {
      OCIOSO        = 3'd0,
      FILTRA        = 3'd1,
      PULSO         = 3'd2,
      INVALIDA      = 3'd3,
      ESPERA_SOLTAR = 3'd4
   } estado_t;

endpackage
`default_nettype wire

// File: rtl/playseq_sincronizador.sv
`default_nettype none
// ===========================================================================
// playseq_sincronizador : parameterised-width two-flop synchroniser.  rev 1.0
// ===========================================================================
module playseq_sincronizador #(
   parameter int LARGURA = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] d,
   output logic [LARGURA-1:0] q
);

   logic [LARGURA-1:0] estagio1_q, estagio1_d;
   logic [LARGURA-1:0] estagio2_q, estagio2_d;

   always_comb begin
      estagio1_d = d;
      estagio2_d = estagio1_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estagio1_q <= '0;
         estagio2_q <= '0;
      end else begin
         estagio1_q <= estagio1_d;
         estagio2_q <= estagio2_d;
      end
   end

   assign q = estagio2_q;

endmodule
`default_nettype wire

// File: rtl/playseq_leitor_jogada.sv
`default_nettype none
// ===========================================================================
// playseq_leitor_jogada : debounces the buttons and emits one event per
//                         accepted one-hot press.                 rev 1.0
// ===========================================================================
module playseq_leitor_jogada
   import playseq_defs::*;
#(
   parameter int N_BOTOES        = N_BOTOES_PADRAO,
   parameter int DEBOUNCE_CICLOS = DEBOUNCE_CICLOS_PADRAO
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                habilita,
   input  logic                limpa,
   input  logic [N_BOTOES-1:0] botoes,
   output logic                tem_jogada,
   output logic [N_BOTOES-1:0] jogada,
   output logic                jogada_invalida,
   output logic [2:0]          db_estado
);

   localparam int                CNT_W   = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);
   localparam logic [CNT_W-1:0] CNT_UM  = CNT_W'(1);

   logic [N_BOTOES-1:0] b_s;
   estado_t             estado_q, estado_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [N_BOTOES-1:0] amostra_q, amostra_d;
   logic [N_BOTOES-1:0] jogada_q, jogada_d;

   playseq_sincronizador #(.LARGURA(N_BOTOES)) u_sinc (
      .clock (clock),
      .reset (reset),
      .d     (botoes),
      .q     (b_s)
   );

   always_comb begin
      estado_d        = estado_q;
      cnt_d           = cnt_q;
      amostra_d       = amostra_q;
      jogada_d        = jogada_q;
      tem_jogada      = 1'b0;
      jogada_invalida = 1'b0;

      // Clear first so that a load on the same edge overrides it.
      if (limpa) jogada_d = '0;

      case (estado_q)
         OCIOSO: begin
            if (habilita && (b_s != '0)) begin
               estado_d  = FILTRA;
               amostra_d = b_s;
               cnt_d     = '0;
            end
         end
         FILTRA: begin
            if (!habilita || (b_s == '0)) begin
               estado_d = OCIOSO;
            end else if (b_s != amostra_q) begin
               amostra_d = b_s;
               cnt_d     = '0;
            end else if (cnt_q == CNT_MAX) begin
               if ($onehot(amostra_q)) begin
                  estado_d = PULSO;
                  jogada_d = amostra_q;
               end else begin
                  estado_d = INVALIDA;
               end
            end else begin
               cnt_d = cnt_q + CNT_UM;
            end
         end
         PULSO: begin
            tem_jogada = 1'b1;
            estado_d   = ESPERA_SOLTAR;
            cnt_d      = '0;
         end
         INVALIDA: begin
            jogada_invalida = 1'b1;
            estado_d        = ESPERA_SOLTAR;
            cnt_d           = '0;
         end
         ESPERA_SOLTAR: begin
            // A held button keeps restarting the release filter.
            if (b_s != '0)           cnt_d    = '0;
            else if (cnt_q == CNT_MAX) estado_d = OCIOSO;
            else                     cnt_d    = cnt_q + CNT_UM;
         end
         default: estado_d = OCIOSO;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado_q  <= OCIOSO;
         cnt_q     <= '0;
         amostra_q <= '0;
         jogada_q  <= '0;
      end else begin
         estado_q  <= estado_d;
         cnt_q     <= cnt_d;
         amostra_q <= amostra_d;
         jogada_q  <= jogada_d;
      end
   end

   assign jogada    = jogada_q;
   assign db_estado = estado_q;

endmodule
`default_nettype wire

// File: tb/tb_playseq_leitor_jogada.sv
`default_nettype none
// ===========================================================================
// tb_playseq_leitor_jogada : directed bench for the button front end.
//                                                                 rev 1.0
// ===========================================================================
module tb_playseq_leitor_jogada;

   localparam int N = 4;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         habilita;
   logic         limpa;
   logic [N-1:0] botoes;
   logic         tem_jogada;
   logic [N-1:0] jogada;
   logic         jogada_invalida;
   logic [2:0]   db_estado;

   int pass_cnt  = 0;
   int total_cnt = 0;

   int         n_tem, n_inv, first_tem, first_inv, n_both;
   logic [2:0] db_hist [0:63];

   playseq_leitor_jogada #(.N_BOTOES(N), .DEBOUNCE_CICLOS(D)) dut (
      .clock           (clk),
      .reset           (rst_n),
      .habilita        (habilita),
      .limpa           (limpa),
      .botoes          (botoes),
      .tem_jogada      (tem_jogada),
      .jogada          (jogada),
      .jogada_invalida (jogada_invalida),
      .db_estado       (db_estado)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, sampling 1 time unit after each; edge 1 is the
   // first edge after the call.
   task automatic observe(input int n);
      n_tem = 0; n_inv = 0; first_tem = 0; first_inv = 0; n_both = 0;
      for (int k = 1; k <= n; k++) begin
         @(posedge clk); #1;
         if (tem_jogada === 1'b1) begin
            n_tem++;
            if (first_tem == 0) first_tem = k;
         end
         if (jogada_invalida === 1'b1) begin
            n_inv++;
            if (first_inv == 0) first_inv = k;
         end
         if (tem_jogada === 1'b1 && jogada_invalida === 1'b1) n_both++;
         if (k < 64) db_hist[k] = db_estado;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; habilita = 1'b0; limpa = 1'b0; botoes = '0;
      repeat (3) @(posedge clk);
      #1;
      total_cnt++;
      if ({tem_jogada, jogada_invalida, jogada, db_estado} !== 9'd0)
         $display("FAIL reset_outputs: got tem=%b inv=%b jogada=%b db=%0d, want all 0",
                  tem_jogada, jogada_invalida, jogada, db_estado);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_press;
      @(negedge clk); habilita = 1'b1; botoes = 4'b0010;
      observe(20);
      total_cnt++;
      if (first_tem !== 7) $display("FAIL press_latency: got edge %0d, want 7", first_tem);
      else pass_cnt++;
      total_cnt++;
      if (n_tem !== 1) $display("FAIL press_count: got %0d pulses, want 1", n_tem);
      else pass_cnt++;
      total_cnt++;
      if (jogada !== 4'b0010) $display("FAIL press_jogada: got %b, want 0010", jogada);
      else pass_cnt++;
      total_cnt++;
      if ({db_hist[2], db_hist[3], db_hist[7], db_hist[8]} !== {3'd0, 3'd1, 3'd2, 3'd4})
         $display("FAIL press_states: got %0d %0d %0d %0d, want 0 1 2 4",
                  db_hist[2], db_hist[3], db_hist[7], db_hist[8]);
      else pass_cnt++;
      total_cnt++;
      if (n_inv !== 0 || n_both !== 0) $display("FAIL press_no_invalid: got inv=%0d both=%0d, want 0 0", n_inv, n_both);
      else pass_cnt++;
      botoes = '0;
      observe(10);
      total_cnt++;
      if (db_estado !== 3'd0) $display("FAIL release_idle: got state %0d, want 0", db_estado);
      else pass_cnt++;
   endtask

   task automatic test_bounce;
      int bounce_pulses;
      bounce_pulses = 0;
      for (int p = 0; p < 6; p++) begin
         botoes = p[0] ? 4'b0000 : 4'b0100;
         observe(2);
         bounce_pulses += n_tem + n_inv;
      end
      total_cnt++;
      if (bounce_pulses !== 0) $display("FAIL bounce_quiet: got %0d events, want 0", bounce_pulses);
      else pass_cnt++;
      botoes = 4'b0100;
      observe(14);
      total_cnt++;
      if (n_tem !== 1 || first_tem !== 7)
         $display("FAIL bounce_pulse: got %0d pulses first at %0d, want 1 at 7", n_tem, first_tem);
      else pass_cnt++;
      total_cnt++;
      if (jogada !== 4'b0100) $display("FAIL bounce_jogada: got %b, want 0100", jogada);
      else pass_cnt++;
      botoes = '0;
      observe(10);
   endtask

   task automatic test_invalida;
      botoes = 4'b0011;
      observe(14);
      total_cnt++;
      if (n_inv !== 1 || first_inv !== 7)
         $display("FAIL invalid_pulse: got %0d pulses first at %0d, want 1 at 7", n_inv, first_inv);
      else pass_cnt++;
      total_cnt++;
      if (n_tem !== 0) $display("FAIL invalid_no_event: got %0d events, want 0", n_tem);
      else pass_cnt++;
      total_cnt++;
      if (jogada !== 4'b0100) $display("FAIL invalid_keep: got %b, want 0100", jogada);
      else pass_cnt++;
      botoes = '0;
      observe(10);
   endtask

   task automatic test_habilita;
      habilita = 1'b0; botoes = 4'b1000;
      observe(10);
      total_cnt++;
      if (n_tem !== 0 || db_estado !== 3'd0)
         $display("FAIL disabled_ignore: got %0d events state %0d, want 0 0", n_tem, db_estado);
      else pass_cnt++;
      habilita = 1'b1;
      observe(10);
      total_cnt++;
      if (n_tem !== 1 || first_tem !== 5 || jogada !== 4'b1000)
         $display("FAIL enable_held: got %0d pulses at %0d jogada %b, want 1 at 5 jogada 1000",
                  n_tem, first_tem, jogada);
      else pass_cnt++;
      botoes = '0;
      observe(10);
      botoes = 4'b0001;
      observe(4);
      total_cnt++;
      if (db_estado !== 3'd1) $display("FAIL filter_entry: got state %0d, want 1", db_estado);
      else pass_cnt++;
      habilita = 1'b0;
      observe(10);
      total_cnt++;
      if (n_tem !== 0 || db_estado !== 3'd0 || jogada !== 4'b1000)
         $display("FAIL disable_abort: got %0d events state %0d jogada %b, want 0 0 1000",
                  n_tem, db_estado, jogada);
      else pass_cnt++;
      botoes = '0;
      observe(4);
      habilita = 1'b1;
      observe(4);
   endtask

   task automatic test_soltar_limpa;
      botoes = 4'b0010;
      observe(12);
      botoes = '0;
      observe(2);
      botoes = 4'b0010;
      observe(10);
      total_cnt++;
      if (n_tem !== 0 || db_estado !== 3'd4)
         $display("FAIL short_release: got %0d events state %0d, want 0 4", n_tem, db_estado);
      else pass_cnt++;
      botoes = '0;
      observe(8);
      total_cnt++;
      if (db_estado !== 3'd0) $display("FAIL release_done: got state %0d, want 0", db_estado);
      else pass_cnt++;
      limpa = 1'b1;
      observe(1);
      limpa = 1'b0;
      total_cnt++;
      if (jogada !== 4'b0000) $display("FAIL limpa_clear: got %b, want 0000", jogada);
      else pass_cnt++;
      botoes = 4'b0001;
      observe(6);
      limpa = 1'b1;
      observe(1);
      limpa = 1'b0;
      total_cnt++;
      if (tem_jogada !== 1'b1 || jogada !== 4'b0001)
         $display("FAIL limpa_vs_load: got tem=%b jogada %b, want 1 0001", tem_jogada, jogada);
      else pass_cnt++;
      observe(4);
   endtask

   task automatic test_reset_async;
      botoes = 4'b0100;
      observe(4);
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (db_estado !== 3'd0 || jogada !== 4'b0000 || tem_jogada !== 1'b0)
         $display("FAIL reset_filtra: got state %0d jogada %b tem %b, want 0 0000 0",
                  db_estado, jogada, tem_jogada);
      else pass_cnt++;
      @(negedge clk); rst_n = 1'b1;
      observe(7);
      total_cnt++;
      if (tem_jogada !== 1'b1 || jogada !== 4'b0100)
         $display("FAIL after_reset_press: got tem %b jogada %b, want 1 0100", tem_jogada, jogada);
      else pass_cnt++;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if (tem_jogada !== 1'b0 || db_estado !== 3'd0 || jogada !== 4'b0000)
         $display("FAIL reset_pulso: got tem %b state %0d jogada %b, want 0 0 0000",
                  tem_jogada, db_estado, jogada);
      else pass_cnt++;
      botoes = '0;
      @(negedge clk); rst_n = 1'b1;
      observe(10);
      total_cnt++;
      if (n_tem !== 0 || db_estado !== 3'd0)
         $display("FAIL reset_no_event: got %0d events state %0d, want 0 0", n_tem, db_estado);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_press();
      test_bounce();
      test_invalida();
      test_habilita();
      test_soltar_limpa();
      test_reset_async();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
`default_nettype wire
